// File: rtl/xor_stream_checksum_pkg.sv
// Shared types and defaults for the XOR stream checksum block.
// State encoding and default geometry live here.
package xor_stream_checksum_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/xor_stream_checksum_xor_reduce.sv
// Parametrised XOR reduction producing a single parity bit.
// Shared with the ALU flags logic.
module xor_reduce #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    // Reduction operator maps onto a balanced XOR tree
    always_comb begin
        parity = ^data;
    end

endmodule

// File: rtl/xor_stream_checksum.sv
// Folds a valid/ready word stream into a per-frame XOR checksum.
// Emits sum, parity and saturating word count at frame end.
module xor_stream_checksum
    import xor_stream_checksum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             cnt_sat;

    logic [WIDTH-1:0] fold;
    logic             fold_parity;
    logic [CNT_W:0]   cnt_inc;
    logic             inc_ovf;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    // Ready depends only on registered state, never on valid/ready inputs
    always_comb begin
        in_ready = (state == ST_ACCUM) && !reset;
        accept   = in_valid && in_ready;
    end

    // Next checksum and widened counter increment with overflow detect
    always_comb begin
        fold     = acc ^ in_data;
        cnt_inc  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
        inc_ovf  = cnt_inc[CNT_W];
        cnt_next = inc_ovf ? cnt : cnt_inc[CNT_W-1:0];
    end

    xor_reduce #(
        .WIDTH (WIDTH)
    ) u_parity (
        .data   (fold),
        .parity (fold_parity)
    );

    // Frame FSM: accumulate words, then hold the result until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ACCUM;
            acc        <= '0;
            cnt        <= '0;
            cnt_sat    <= 1'b0;
            out_sum    <= '0;
            out_parity <= 1'b0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                ST_ACCUM: begin
                    if (abort) begin
                        acc     <= '0;
                        cnt     <= '0;
                        cnt_sat <= 1'b0;
                    end else if (accept) begin
                        if (in_last) begin
                            out_sum    <= fold;
                            out_parity <= fold_parity;
                            out_count  <= cnt_next;
                            out_ovf    <= cnt_sat | inc_ovf;
                            out_valid  <= 1'b1;
                            acc        <= '0;
                            cnt        <= '0;
                            cnt_sat    <= 1'b0;
                            state      <= ST_OUT;
                        end else begin
                            acc     <= fold;
                            cnt     <= cnt_next;
                            cnt_sat <= cnt_sat | inc_ovf;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Directed testbench for xor_stream_checksum at WIDTH=8, CNT_W=4.
// Expected values are hand-computed constants.
module tb_xor_stream_checksum;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       abort;
    logic [7:0] out_sum;
    logic       out_parity;
    logic [3:0] out_count;
    logic       out_ovf;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    xor_stream_checksum #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .abort      (abort),
        .out_sum    (out_sum),
        .out_parity (out_parity),
        .out_count  (out_count),
        .out_ovf    (out_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int k;
        k = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        if (!in_ready) check("send_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] s,
                             input logic p, input logic [3:0] c,
                             input logic o);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_sum"}, {24'd0, out_sum}, {24'd0, s});
        check({tag, "_par"}, {31'd0, out_parity}, {31'd0, p});
        check({tag, "_cnt"}, {28'd0, out_count}, {28'd0, c});
        check({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, o});
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {24'd0, out_sum}, 32'd0);
        check("rst_cnt", {28'd0, out_count}, 32'd0);
        check("rst_par", {31'd0, out_parity}, 32'd0);
        check("rst_ovf", {31'd0, out_ovf}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Basic three-word frame
        send(8'h0F, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h3C, 1'b1);
        check_out("f1", 8'hC3, 1'b0, 4'd3, 1'b0);
        check("f1_busy", {31'd0, in_ready}, 32'd0);
        step();
        check("f1_hs_valid", {31'd0, out_valid}, 32'd0);
        check("f1_hs_ready", {31'd0, in_ready}, 32'd1);

        // Single-word frame, then cancelling pair
        send(8'h01, 1'b1);
        check_out("f2", 8'h01, 1'b1, 4'd1, 1'b0);
        step();
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        check_out("f3", 8'h00, 1'b0, 4'd2, 1'b0);
        step();

        // Backpressure with a pending word on the input
        out_ready = 1'b0;
        send(8'hA5, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_out("bp", 8'hA5, 1'b0, 4'd1, 1'b0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_rel_valid", {31'd0, out_valid}, 32'd0);
        check("bp_rel_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_out("bp_next", 8'h77, 1'b0, 4'd1, 1'b0);
        step();

        // Saturation: 17 words in one frame
        for (int i = 0; i < 16; i++) send(8'h01, 1'b0);
        send(8'h01, 1'b1);
        check_out("sat", 8'h01, 1'b1, 4'd15, 1'b1);
        step();
        send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        check_out("post_sat", 8'h01, 1'b1, 4'd2, 1'b0);
        step();

        // Abort wins over a simultaneous last word
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b1;
        abort    = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("abort_valid0", {31'd0, out_valid}, 32'd0);
        step();
        check("abort_valid1", {31'd0, out_valid}, 32'd0);
        send(8'h55, 1'b1);
        check_out("post_abort", 8'h55, 1'b0, 4'd1, 1'b0);
        step();

        // Reset mid-frame
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("midrst_sum", {24'd0, out_sum}, 32'd0);
        check("midrst_cnt", {28'd0, out_count}, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_after", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        send(8'h0A, 1'b1);
        check_out("post_rst", 8'h0A, 1'b0, 4'd1, 1'b0);

        // Reset while the result is pending
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("outrst_valid", {31'd0, out_valid}, 32'd0);
        check("outrst_sum", {24'd0, out_sum}, 32'd0);
        check("outrst_ready", {31'd0, in_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
